// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// Module : mips_ctrl_pkg
// Brief  : Shared state, opcode, funct and ALU control encodings for the
//          multicycle MIPS control unit.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ---------------------------------------------------------------------------
// Module : alu_decoder
// Brief  : Maps the FSM alu_op and the R-type funct field to alu_control.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6
) (
   input  logic [FUNCT_W-1:0] funct,
   input  logic [1:0]         alu_op,
   output logic [2:0]         alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            // Unknown funct codes quietly fall back to add.
            case (funct)
               FUNCT_ADD: alu_control = ALU_ADD;
               FUNCT_SUB: alu_control = ALU_SUB;
               FUNCT_AND: alu_control = ALU_AND;
               FUNCT_OR:  alu_control = ALU_OR;
               FUNCT_SLT: alu_control = ALU_SLT;
               default:   alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// Module : multicycle_control_unit
// Brief  : Control FSM of the multicycle MIPS core (lw, sw, R-type, beq,
//          addi, j). Outputs are decoded from the current state.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    opcode,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_en,
   output logic               iord,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_src,
   output logic [2:0]         alu_control,
   output logic               instr_done,
   output logic               illegal
);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] alu_op;
   logic       pc_write;
   logic       branch;

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   if (mem_ready) state_d = MEMWB;
         MEMWR:   if (mem_ready) state_d = FETCH;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
               default: illegal = 1'b1;
            endcase
         end
         MEMADR, ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: iord = 1'b1;
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
         end
         RTYPEEX: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         BEQEX: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_SUB;
            pc_src     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         JEX: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      pc_en = pc_write | (branch & zero);
      // Reset suppresses every side effect of the state being aborted.
      if (reset) begin
         pc_en      = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

   alu_decoder #(
      .FUNCT_W (FUNCT_W)
   ) u_alu_decoder (
      .funct       (funct),
      .alu_op      (alu_op),
      .alu_control (alu_control)
   );

endmodule

`default_nettype wire
